// File: rtl/vcve2_pkg.sv
// Shared types for the vector writeback path.
// Element-width and writeback-sequencer state encodings.
package vcve2_pkg;

   localparam int VRF_DATA_W = 32;

   typedef enum logic [1:0] {
      SEW8,
      SEW16,
      SEW32,
      SEW_RSVD
   } vsew_e;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      FINISH
   } vwb_state_e;

endpackage

// File: rtl/vcve2_vrf_wb_seq.sv
// Writes one vector result into the VRF, one 32-bit word per cycle.
// Source is either the vector ALU or LSU load data, selected at start.
module vcve2_vrf_wb_seq
   import vcve2_pkg::*;
#(
   parameter int VLEN = 128,
   localparam int WPR = VLEN / 32,
   localparam int WIDX_W = (WPR > 1) ? $clog2(WPR) : 1,
   localparam int CNT_W = $clog2(8 * WPR) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   output logic                  start_ready_o,
   input  logic [4:0]            vd_i,
   input  logic [31:0]           vl_i,
   input  logic [1:0]            vsew_i,
   input  logic                  is_mem_i,
   input  logic                  alu_valid_i,
   input  logic [VRF_DATA_W-1:0] alu_wdata_i,
   output logic                  alu_ready_o,
   input  logic                  lsu_valid_i,
   input  logic [VRF_DATA_W-1:0] lsu_wdata_i,
   output logic                  lsu_ready_o,
   input  logic                  flush_i,
   output logic                  vrf_we_o,
   output logic [4:0]            vrf_waddr_o,
   output logic [WIDX_W-1:0]     vrf_word_o,
   output logic [VRF_DATA_W-1:0] vrf_wdata_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int MAXW = 8 * WPR;

   function automatic logic [34:0] calc_words(
      input logic [31:0] vl,
      input vsew_e       sew
   );
      logic [34:0] nbytes;
      nbytes = {3'b000, vl} << sew;
      return (nbytes + 35'd3) >> 2;
   endfunction

   vwb_state_e state_q, state_d;
   logic [CNT_W-1:0] wcnt_q;
   logic [CNT_W-1:0] nwords_q;
   logic [4:0] vd_q;
   logic is_mem_q;

   vsew_e sew_eff;
   logic sew_rsvd;
   logic [34:0] words_raw;
   logic sat;
   logic [CNT_W-1:0] nwords_d;
   logic start_acc;
   logic active;
   logic acc;
   logic last;
   logic [VRF_DATA_W-1:0] beat_data;
   logic [5:0] reg_sum;
   logic [WIDX_W-1:0] word_idx;

   assign sew_rsvd = (vsew_i == 2'd3);
   assign sew_eff = sew_rsvd ? SEW32 : vsew_e'(vsew_i);
   assign words_raw = calc_words(vl_i, sew_eff);
   assign sat = words_raw > 35'(MAXW);
   assign nwords_d = sat ? CNT_W'(MAXW) : words_raw[CNT_W-1:0];

   assign start_ready_o = (state_q == IDLE);
   assign start_acc = start_i & start_ready_o & ~flush_i;
   assign busy_o = (state_q != IDLE);
   assign done_o = (state_q == FINISH);

   // flush drops ready combinationally so no beat is taken that cycle
   assign active = (state_q == ACTIVE) & ~flush_i;
   assign alu_ready_o = active & ~is_mem_q;
   assign lsu_ready_o = active & is_mem_q;
   assign acc = is_mem_q ? (lsu_valid_i & lsu_ready_o)
                         : (alu_valid_i & alu_ready_o);
   assign beat_data = is_mem_q ? lsu_wdata_i : alu_wdata_i;
   assign last = (wcnt_q == nwords_q - CNT_W'(1));

   // bit 5 of the sum flags a register group running past v31
   assign reg_sum = {1'b0, vd_q} + 6'(wcnt_q / CNT_W'(WPR));
   assign word_idx = WIDX_W'(wcnt_q % CNT_W'(WPR));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) state_d = (nwords_d == '0) ? FINISH : ACTIVE;
         end
         ACTIVE: begin
            if (acc && last) state_d = FINISH;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         wcnt_q <= '0;
         nwords_q <= '0;
         vd_q <= '0;
         is_mem_q <= 1'b0;
         err_o <= 1'b0;
      end else begin
         state_q <= state_d;
         if (flush_i) begin
            wcnt_q <= '0;
         end else if (start_acc) begin
            vd_q <= vd_i;
            is_mem_q <= is_mem_i;
            nwords_q <= nwords_d;
            wcnt_q <= '0;
            err_o <= sat | sew_rsvd;
         end else if (acc) begin
            wcnt_q <= wcnt_q + CNT_W'(1);
            if (reg_sum[5]) err_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vrf_we_o <= 1'b0;
         vrf_waddr_o <= '0;
         vrf_word_o <= '0;
         vrf_wdata_o <= '0;
      end else begin
         vrf_we_o <= acc;
         if (acc) begin
            vrf_waddr_o <= reg_sum[4:0];
            vrf_word_o <= word_idx;
            vrf_wdata_o <= beat_data;
         end
      end
   end

   a_we_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
      vrf_we_o |-> $past(busy_o));
   a_one_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(alu_ready_o && lsu_ready_o));
   a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
      done_o |=> !done_o);

endmodule

// File: doc/vcve2_vrf_wb_seq.md
Name: vcve2_vrf_wb_seq

Overview:
- Sequences the writeback of one vector instruction's result into the VRF through its 32-bit write port, one word per cycle.
- Sits between the vector execute/LSU result producers and the writeback passthrough.
- Latches the instruction context (vd, vl, SEW, memory/non-memory) at start, then accepts result words from exactly one source (vector ALU or LSU load data) via valid/ready.
- Emits registered VRF writes with register/word addressing, and signals completion.

Parameters:
- VLEN, 128, vector register length in bits; multiple of 32, at least 32.
- WPR, VLEN/32, derived: 32-bit words per vector register.
- WIDX_W, $clog2(WPR) (minimum 1), derived: width of the word index.
- CNT_W, $clog2(8*WPR)+1, derived: width of the word counter (covers LMUL=8).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start request; accepted only when start_ready_o=1
- start_ready_o  out  1  high in IDLE
- vd_i  in  5  destination base register
- vl_i  in  32  vector length in elements
- vsew_i  in  2  element width: 0=8b, 1=16b, 2=32b; 3 is reserved
- is_mem_i  in  1  1 = data comes from LSU, 0 = data comes from ALU
- alu_valid_i  in  1  ALU result word valid
- alu_wdata_i  in  32  ALU result word
- alu_ready_o  out  1  ALU handshake ready
- lsu_valid_i  in  1  LSU load word valid
- lsu_wdata_i  in  32  LSU load word
- lsu_ready_o  out  1  LSU handshake ready
- flush_i  in  1  abort current sequence
- vrf_we_o  out  1  VRF write enable (registered)
- vrf_waddr_o  out  5  VRF register index
- vrf_word_o  out  WIDX_W  word index within the register
- vrf_wdata_o  out  32  write data
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky until next accepted start: reserved SEW, or register group wrapped past v31

Behaviour:
- Clocking: single clock clk_i; reset is asynchronous, active-low on rst_ni.
- Reset values: state=IDLE; all counters 0; vrf_we_o=0, vrf_waddr_o=0, vrf_word_o=0, vrf_wdata_o=0, done_o=0, err_o=0, busy_o=0.
- States: IDLE, ACTIVE, FINISH.
- Start (start_i & IDLE):
  - Latch vd, is_mem.
  - nwords = ((vl_i << vsew_i) + 3) >> 2, computed with 35-bit intermediate.
  - If nwords exceeds 8*WPR, saturate to 8*WPR and set err_o.
  - vsew_i=3 sets err_o and behaves as SEW=32.
  - Clear word counter wcnt. err_o is cleared here, then set if applicable.
  - Next state: nwords==0 -> FINISH; otherwise ACTIVE.
- start_i while not IDLE is ignored (no state change, no latch).
- ACTIVE:
  - alu_ready_o = ~is_mem_q; lsu_ready_o = is_mem_q. Both are 0 outside ACTIVE.
  - A beat is accepted when the selected source has valid & ready. The unselected source's valid is ignored.
  - An accepted beat in cycle N gives vrf_we_o=1 in cycle N+1 with:
    - vrf_wdata_o = accepted data;
    - vrf_waddr_o = (vd_q + wcnt/WPR) mod 32;
    - vrf_word_o = wcnt mod WPR.
  - wcnt increments on each accepted beat.
  - A register index that wraps past 31 sets err_o; the write still occurs at the wrapped address.
  - The last beat (wcnt==nwords-1 accepted) moves the state to FINISH.
  - Maximum throughput is one beat per cycle; no bubbles are inserted.
- FINISH:
  - Lasts one cycle. done_o=1, aligned with the final vrf_we_o (or with no write when vl=0). Then IDLE.
  - start_ready_o=0 during FINISH.
- vrf_we_o is 0 in every cycle not following an accepted beat. Data and address registers hold their values when not writing.
- flush_i: highest priority, in any state.
  - Next state IDLE; wcnt cleared.
  - A beat presented in the same cycle is not accepted: ready is forced to 0 combinationally when flush_i=1.
  - The write from a beat accepted in the previous cycle still completes.
  - No done_o pulse; err_o is retained.
- flush_i coinciding with start_i: flush wins; the start is dropped.
- Reset mid-operation returns all state to reset values immediately (asynchronous).

Decomposition:
- vcve2_pkg: add vsew_e enum (SEW8, SEW16, SEW32, SEW_RSVD), VRF_DATA_W=32, and vwb_state_e (IDLE, ACTIVE, FINISH).
- No sub-module; the word-count computation is a local function inside the block.
- Assertions:
  - vrf_we_o implies busy_o was high in the previous cycle.
  - alu_ready_o & lsu_ready_o never both high.
  - done_o is a single-cycle pulse.

Test Plan (VLEN=128, WPR=4):
- vd=2, vl=4, sew=32, ALU valid held high -> 4 writes on consecutive cycles: (v2,w0..w3); done_o with the 4th write; 6 cycles from start to IDLE.
- vd=1, vl=10, sew=8, is_mem=1 -> 3 writes (v1,w0..w2) with LSU data; alu_valid_i=1 throughout is never accepted (alu_ready_o=0).
- vd=4, vl=9, sew=32, valid toggling 1/0 -> writes v4 w0-3, v5 w0-3, v6 w0, each one cycle after its handshake; exactly 9 writes.
- vl=0 -> no vrf_we_o; done_o pulses 1 cycle after start; return to IDLE.
- vd=30, vl=12, sew=32 -> writes to v30, v31, v0 (wrapped); err_o=1 until the next start.
- flush_i after 2 accepted beats of an 8-word sequence -> exactly 2 writes, no done_o, IDLE next cycle; a start_i during busy is ignored, and a new start after IDLE succeeds.
